// File: rtl/arcade_input_ctrl.sv
// Arcade control front end: PS/2 key latches merged with two joypads into
// per-player csjudlr words, plus a start-triggered coin pulse with lockout.
module arcade_input_ctrl #(
    parameter int COIN_LEN = 1200000,
    parameter int GAP_LEN  = 1200000,
    parameter int CW       = 21
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        horz,
    output logic [6:0]  p1_csjudlr,
    output logic [6:0]  p2_csjudlr,
    output logic        coin_busy
);

    // state | meaning
    // IDLE  | waiting for a rising edge of start1|start2
    // COIN  | coin bit high, counter runs COIN_LEN cycles
    // GAP   | coin lockout, counter runs GAP_LEN cycles, start edges ignored
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COIN = 2'd1,
        S_GAP  = 2'd2
    } coin_state_t;

    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_LEN - 1);

    logic       tog_q;
    logic       armed_q;
    logic       key_event;
    logic       key_pressed;
    logic       key_ext;
    logic [7:0] key_code;

    logic k_up_q, k_down_q, k_left_q, k_right_q, k_fire_q, k_one_q, k_two_q;
    logic k_up_d, k_down_d, k_left_d, k_right_d, k_fire_d, k_one_d, k_two_d;

    logic [15:0] joy;
    logic [8:0]  unused_joy_hi;
    logic        up_c, down_c, left_c, right_c, fire_c, start1_c, start2_c;
    logic        up_q, down_q, left_q, right_q, fire_q, start1_q, start2_q;

    coin_state_t    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           start_any;
    logic           start_q;
    logic           start_rise;
    logic           coin;

    assign key_pressed = ps2_key[9];
    assign key_ext     = ps2_key[8];
    assign key_code    = ps2_key[7:0];

    // The first edge after reset only captures the strobe level, so a
    // strobe already high at release is not taken as a key event.
    assign key_event = armed_q & (ps2_key[10] ^ tog_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        k_up_d    = k_up_q;
        k_down_d  = k_down_q;
        k_left_d  = k_left_q;
        k_right_d = k_right_q;
        k_fire_d  = k_fire_q;
        k_one_d   = k_one_q;
        k_two_d   = k_two_q;
        if (key_event) begin
            case (key_code)
                8'h75: k_up_d    = key_pressed;
                8'h72: k_down_d  = key_pressed;
                8'h6B: k_left_d  = key_pressed;
                8'h74: k_right_d = key_pressed;
                8'h29, 8'h14: if (!key_ext) k_fire_d = key_pressed;
                8'h05: if (!key_ext) k_one_d = key_pressed;
                8'h06: if (!key_ext) k_two_d = key_pressed;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            k_up_q    <= 1'b0;
            k_down_q  <= 1'b0;
            k_left_q  <= 1'b0;
            k_right_q <= 1'b0;
            k_fire_q  <= 1'b0;
            k_one_q   <= 1'b0;
            k_two_q   <= 1'b0;
        end else begin
            k_up_q    <= k_up_d;
            k_down_q  <= k_down_d;
            k_left_q  <= k_left_d;
            k_right_q <= k_right_d;
            k_fire_q  <= k_fire_d;
            k_one_q   <= k_one_d;
            k_two_q   <= k_two_d;
        end
    end

    assign joy           = joystick_0 | joystick_1;
    assign unused_joy_hi = joy[15:7];

    // Horizontal cabinets rotate the stick a quarter turn.
    always_comb begin
        if (horz) begin
            up_c    = k_left_q  | joy[1];
            down_c  = k_right_q | joy[0];
            left_c  = k_down_q  | joy[2];
            right_c = k_up_q    | joy[3];
        end else begin
            up_c    = k_up_q    | joy[3];
            down_c  = k_down_q  | joy[2];
            left_c  = k_left_q  | joy[1];
            right_c = k_right_q | joy[0];
        end
        fire_c   = k_fire_q | joy[4];
        start1_c = k_one_q  | joy[5];
        start2_c = k_two_q  | joy[6];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            fire_q   <= 1'b0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
        end else begin
            up_q     <= up_c;
            down_q   <= down_c;
            left_q   <= left_c;
            right_q  <= right_c;
            fire_q   <= fire_c;
            start1_q <= start1_c;
            start2_q <= start2_c;
        end
    end

    // Edge detect on the merged start so coin and start appear together.
    assign start_any  = start1_c | start2_c;
    assign start_rise = start_any & ~start_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_COIN;
                    cnt_d   = COIN_LOAD;
                end
            end
            S_COIN: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_any;
        end
    end

    assign coin      = (state_q == S_COIN);
    assign coin_busy = (state_q != S_IDLE);

    assign p1_csjudlr = {coin, start1_q, fire_q, 2'b00, left_q, right_q};
    assign p2_csjudlr = {1'b0, start2_q, fire_q, 2'b00, down_q, up_q};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: behavioural model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_arcade_input_ctrl;

    localparam int COIN_LEN = 4;
    localparam int GAP_LEN  = 3;
    localparam int CW       = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        horz;
    logic [6:0]  p1_csjudlr;
    logic [6:0]  p2_csjudlr;
    logic        coin_busy;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // model: latch bits 0 up, 1 down, 2 left, 3 right, 4 fire, 5 one, 6 two
    logic [6:0] lat;
    logic       tog_prev;
    bit         tog_valid;
    bit         start_prev;
    int         coin_left;
    int         busy_left;
    logic [6:0] exp_p1, exp_p2;
    logic       exp_busy;

    arcade_input_ctrl #(.COIN_LEN(COIN_LEN), .GAP_LEN(GAP_LEN), .CW(CW)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .horz       (horz),
        .p1_csjudlr (p1_csjudlr),
        .p2_csjudlr (p2_csjudlr),
        .coin_busy  (coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    function automatic int key_index(input logic ext, input logic [7:0] code);
        if (code == 8'h75) return 0;
        if (code == 8'h72) return 1;
        if (code == 8'h6B) return 2;
        if (code == 8'h74) return 3;
        if (ext) return -1;
        if (code == 8'h29 || code == 8'h14) return 4;
        if (code == 8'h05) return 5;
        if (code == 8'h06) return 6;
        return -1;
    endfunction

    task automatic model_reset();
        lat        = '0;
        tog_prev   = 1'b0;
        tog_valid  = 1'b0;
        start_prev = 1'b0;
        coin_left  = 0;
        busy_left  = 0;
        exp_p1     = '0;
        exp_p2     = '0;
        exp_busy   = 1'b0;
    endtask

    task automatic model_update();
        logic [15:0] j;
        logic u, d, l, r, eu, ed, el, er, f, s1, s2, st;
        int idx;
        if (!reset_n) begin
            model_reset();
            return;
        end
        j  = joystick_0 | joystick_1;
        u  = lat[0] | j[3];
        d  = lat[1] | j[2];
        l  = lat[2] | j[1];
        r  = lat[3] | j[0];
        eu = horz ? l : u;
        ed = horz ? r : d;
        el = horz ? d : l;
        er = horz ? u : r;
        f  = lat[4] | j[4];
        s1 = lat[5] | j[5];
        s2 = lat[6] | j[6];
        st = s1 | s2;
        if (busy_left > 0) begin
            busy_left--;
            if (coin_left > 0) coin_left--;
        end else if (st && !start_prev) begin
            coin_left = COIN_LEN;
            busy_left = COIN_LEN + GAP_LEN;
        end
        start_prev = st;
        exp_p1   = {coin_left > 0, s1, f, 2'b00, el, er};
        exp_p2   = {1'b0, s2, f, 2'b00, ed, eu};
        exp_busy = busy_left > 0;
        if (tog_valid && ps2_key[10] != tog_prev) begin
            idx = key_index(ps2_key[8], ps2_key[7:0]);
            if (idx >= 0) lat[idx] = ps2_key[9];
        end
        tog_prev  = ps2_key[10];
        tog_valid = 1'b1;
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("model_p1", {25'd0, p1_csjudlr}, {25'd0, exp_p1});
            check("model_p2", {25'd0, p2_csjudlr}, {25'd0, exp_p2});
            check("model_busy", {31'd0, coin_busy}, {31'd0, exp_busy});
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        model_update();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int coin_cnt, busy_cnt, start_gap;
        reset_n    = 1'b0;
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        horz       = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) tick();
        check("reset_p1", {25'd0, p1_csjudlr}, 32'd0);
        check("reset_p2", {25'd0, p2_csjudlr}, 32'd0);
        check("reset_busy", {31'd0, coin_busy}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // up key, vertical then horizontal mapping
        send_key(1'b1, 1'b0, 8'h75);
        tick();
        check("key_up_p2_0", {31'd0, p2_csjudlr[0]}, 32'd1);
        send_key(1'b0, 1'b0, 8'h75);
        tick();
        check("key_up_rel_p2_0", {31'd0, p2_csjudlr[0]}, 32'd0);
        horz = 1'b1;
        send_key(1'b1, 1'b0, 8'h75);
        tick();
        check("horz_up_p1_0", {31'd0, p1_csjudlr[0]}, 32'd1);
        check("horz_up_p2", {25'd0, p2_csjudlr}, 32'd0);
        send_key(1'b0, 1'b1, 8'h75);
        tick();
        horz = 1'b0;

        // joystick direct paths and mixed key+joy in one cycle
        joystick_0 = 16'h0008;
        tick();
        check("joy_up_p2", {25'd0, p2_csjudlr}, 32'h01);
        horz = 1'b1;
        tick();
        check("joy_up_horz_p1", {25'd0, p1_csjudlr}, 32'h01);
        horz = 1'b0;
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0012;
        ps2_key    = {~ps2_key[10], 1'b1, 1'b0, 8'h74};
        tick();
        check("mix_joy_p1", {25'd0, p1_csjudlr}, 32'h12);
        tick();
        check("mix_key_p1", {25'd0, p1_csjudlr}, 32'h13);
        joystick_1 = 16'h0000;
        send_key(1'b0, 1'b0, 8'h74);
        send_key(1'b1, 1'b1, 8'h29);
        tick();
        check("ext_fire_ignored", {25'd0, p1_csjudlr}, 32'h00);

        // coin pulse held start: no retrigger
        joystick_1 = 16'h0020;
        coin_cnt = 0; busy_cnt = 0; start_gap = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (p1_csjudlr[6]) coin_cnt++;
            if (coin_busy) busy_cnt++;
            if (!p1_csjudlr[5]) start_gap++;
        end
        check("coin_len", coin_cnt, 32'd4);
        check("busy_len", busy_cnt, 32'd7);
        check("start_held", start_gap, 32'd0);
        joystick_1 = 16'h0000;
        tick();

        // both starts at once, re-press in GAP ignored, press after IDLE accepted
        joystick_0 = 16'h0020;
        joystick_1 = 16'h0040;
        coin_cnt = 0;
        tick();
        if (p1_csjudlr[6]) coin_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (p1_csjudlr[6]) coin_cnt++;
        end
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        tick();
        if (p1_csjudlr[6]) coin_cnt++;
        joystick_0 = 16'h0020;
        tick();
        if (p1_csjudlr[6]) coin_cnt++;
        joystick_0 = 16'h0000;
        tick();
        if (p1_csjudlr[6]) coin_cnt++;
        check("dual_start_one_pulse", coin_cnt, 32'd4);
        check("idle_reentered", {31'd0, coin_busy}, 32'd0);
        joystick_0 = 16'h0020;
        coin_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p1_csjudlr[6]) coin_cnt++;
        end
        check("repress_pulse", coin_cnt, 32'd4);
        joystick_0 = 16'h0000;
        busy_cnt = 0;
        while (coin_busy && busy_cnt < 30) begin
            tick();
            busy_cnt++;
        end
        check("busy_drain", {31'd0, coin_busy}, 32'd0);
        tick();

        // async reset during COIN, strobe high through release
        if (ps2_key[10]) send_key(1'b0, 1'b0, 8'h1C);
        joystick_0 = 16'h0020;
        tick();
        tick();
        check("coin_before_reset", {31'd0, p1_csjudlr[6]}, 32'd1);
        reset_n = 1'b0;
        model_reset();
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
        #1;
        check("reset_drops_coin", {31'd0, p1_csjudlr[6]}, 32'd0);
        check("reset_drops_busy", {31'd0, coin_busy}, 32'd0);
        joystick_0 = 16'h0000;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_reset_p1", {25'd0, p1_csjudlr}, 32'd0);
        check("post_reset_p2", {25'd0, p2_csjudlr}, 32'd0);

        // unmapped code, then fire
        send_key(1'b1, 1'b0, 8'h1C);
        tick();
        check("unmapped_p1", {25'd0, p1_csjudlr}, 32'd0);
        check("unmapped_p2", {25'd0, p2_csjudlr}, 32'd0);
        send_key(1'b1, 1'b0, 8'h14);
        tick();
        check("fire_p1_4", {31'd0, p1_csjudlr[4]}, 32'd1);
        check("fire_p2_4", {31'd0, p2_csjudlr[4]}, 32'd1);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
